// File: rtl/ad_scan_ctrl.sv
// Scan sequencer for an 11-channel serial 10-bit ADC (TLC1543-style, pipelined readback).
// Define AD_SCAN_AVG_EN to address each channel in 4 frames and report the averaged result.
module ad_scan_ctrl #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned CS_SETUP    = 50,
  parameter int unsigned EOC_TIMEOUT = 2000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        Cont_En,
  input  logic [10:0] Ch_Mask,
  input  logic        AD_EOC,
  input  logic        AD_DigData_In,
  output logic        AD_CSn,
  output logic        AD_Clk,
  output logic        AD_Address,
  output logic [9:0]  Result_Data,
  output logic [3:0]  Result_Ch,
  output logic        Result_Valid,
  output logic        Busy,
  output logic        Timeout_Err
);

  localparam int unsigned CNT_MAX =
    (EOC_TIMEOUT > CS_SETUP) ? ((EOC_TIMEOUT > CLK_DIV) ? EOC_TIMEOUT : CLK_DIV)
                             : ((CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV);
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_LOW, S_SHIFT, S_EOC_FALL, S_EOC_RISE, S_NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   mask_q, mask_d;
  logic [3:0]    cur_ch_q, cur_ch_d;
  logic [3:0]    prev_ch_q, prev_ch_d;
  logic          first_q, first_d;
  logic          flush_q, flush_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    asr_q, asr_d;
  logic          csn_q, csn_d;
  logic          sclk_q, sclk_d;
  logic [9:0]    rdata_q, rdata_d;
  logic [3:0]    rch_q, rch_d;
  logic          rvalid_q, rvalid_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          start_go;
  logic [4:0]    hit, nxt;
`ifdef AD_SCAN_AVG_EN
  logic [11:0]   sum_q, sum_d;
  logic [1:0]    rep_q, rep_d;
  logic [1:0]    prev_rep_q, prev_rep_d;
  logic [11:0]   acc;
`endif

  // Lowest enabled channel at or above 'from'; bit 4 flags a hit.
  function automatic logic [4:0] find_ch(input logic [10:0] m, input logic [3:0] from);
    logic [4:0] r;
    logic [3:0] idx;
    r = '0;
    for (int unsigned i = 0; i < 11; i++) begin
      idx = 4'(10 - i);
      if (m[idx] && (idx >= from)) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    mask_d    = mask_q;
    cur_ch_d  = cur_ch_q;
    prev_ch_d = prev_ch_q;
    first_d   = first_q;
    flush_d   = flush_q;
    sh_d      = sh_q;
    asr_d     = asr_q;
    csn_d     = csn_q;
    sclk_d    = sclk_q;
    rdata_d   = rdata_q;
    rch_d     = rch_q;
    rvalid_d  = 1'b0;
    busy_d    = busy_q;
    terr_d    = terr_q;
    start_go  = 1'b0;
    hit       = '0;
    nxt       = '0;
`ifdef AD_SCAN_AVG_EN
    sum_d      = sum_q;
    rep_d      = rep_q;
    prev_rep_d = prev_rep_q;
    acc        = '0;
`endif

    case (state_q)
      S_IDLE: start_go = Start && (Ch_Mask != '0);

      // The setup window doubles as the low phase of the first AD_Clk period.
      S_CS_LOW: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          sclk_d  = 1'b1;
          sh_d    = {sh_q[8:0], AD_DigData_In};
          bit_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            asr_d  = {asr_q[2:0], 1'b0};
            if (bit_q == 4'd9) begin
              csn_d   = 1'b1;
              state_d = S_EOC_FALL;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            sclk_d = 1'b1;
            sh_d   = {sh_q[8:0], AD_DigData_In};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_EOC_FALL, S_EOC_RISE: begin
        if (AD_EOC == (state_q == S_EOC_RISE)) begin
          cnt_d   = '0;
          state_d = (state_q == S_EOC_FALL) ? S_EOC_RISE : S_NEXT;
        end else if (cnt_q == CW'(EOC_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_NEXT: begin
        // Data just shifted in belongs to the address sent in the previous frame.
`ifdef AD_SCAN_AVG_EN
        if (!first_q) begin
          acc   = ((prev_rep_q == 2'd0) ? 12'd0 : sum_q) + {2'b00, sh_q};
          sum_d = acc;
          if (prev_rep_q == 2'd3) begin
            rvalid_d = 1'b1;
            rdata_d  = acc[11:2];
            rch_d    = prev_ch_q;
          end
        end
        prev_rep_d = rep_q;
`else
        if (!first_q) begin
          rvalid_d = 1'b1;
          rdata_d  = sh_q;
          rch_d    = prev_ch_q;
        end
`endif
        prev_ch_d = cur_ch_q;
        first_d   = 1'b0;
        if (flush_q) begin
          if (Cont_En && (Ch_Mask != '0)) begin
            start_go = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_CS_LOW;
`ifdef AD_SCAN_AVG_EN
          if (rep_q != 2'd3) begin
            rep_d = rep_q + 2'd1;
          end else begin
            rep_d = '0;
            nxt   = find_ch(mask_q, cur_ch_q + 4'd1);
            if (nxt[4]) cur_ch_d = nxt[3:0];
            else        flush_d  = 1'b1;
          end
`else
          nxt = find_ch(mask_q, cur_ch_q + 4'd1);
          if (nxt[4]) cur_ch_d = nxt[3:0];
          else        flush_d  = 1'b1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start_go) begin
      hit      = find_ch(Ch_Mask, 4'd0);
      mask_d   = Ch_Mask;
      cur_ch_d = hit[3:0];
      first_d  = 1'b1;
      flush_d  = 1'b0;
      terr_d   = 1'b0;
      busy_d   = 1'b1;
      state_d  = S_CS_LOW;
`ifdef AD_SCAN_AVG_EN
      rep_d    = '0;
`endif
    end

    if ((state_d == S_CS_LOW) && (state_q != S_CS_LOW)) begin
      csn_d = 1'b0;
      asr_d = cur_ch_d;
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      mask_q    <= '0;
      cur_ch_q  <= '0;
      prev_ch_q <= '0;
      first_q   <= 1'b0;
      flush_q   <= 1'b0;
      sh_q      <= '0;
      asr_q     <= '0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b0;
      rdata_q   <= '0;
      rch_q     <= '0;
      rvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
`ifdef AD_SCAN_AVG_EN
      sum_q      <= '0;
      rep_q      <= '0;
      prev_rep_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      mask_q    <= mask_d;
      cur_ch_q  <= cur_ch_d;
      prev_ch_q <= prev_ch_d;
      first_q   <= first_d;
      flush_q   <= flush_d;
      sh_q      <= sh_d;
      asr_q     <= asr_d;
      csn_q     <= csn_d;
      sclk_q    <= sclk_d;
      rdata_q   <= rdata_d;
      rch_q     <= rch_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
`ifdef AD_SCAN_AVG_EN
      sum_q      <= sum_d;
      rep_q      <= rep_d;
      prev_rep_q <= prev_rep_d;
`endif
    end
  end

  assign AD_CSn       = csn_q;
  assign AD_Clk       = sclk_q;
  assign AD_Address   = asr_q[3];
  assign Result_Data  = rdata_q;
  assign Result_Ch    = rch_q;
  assign Result_Valid = rvalid_q;
  assign Busy         = busy_q;
  assign Timeout_Err  = terr_q;

endmodule

// File: tb/tb_ad_scan_ctrl.sv
// Scoreboard bench for ad_scan_ctrl: ADC behavioural model, expected-result queue, monitor.
module tb_ad_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        Cont_En = 1'b0;
  logic [10:0] Ch_Mask = '0;
  logic        AD_EOC = 1'b1;
  logic        AD_DigData_In = 1'b0;
  logic        AD_CSn, AD_Clk, AD_Address, Result_Valid, Busy, Timeout_Err;
  logic [9:0]  Result_Data;
  logic [3:0]  Result_Ch;

  ad_scan_ctrl #(.CLK_DIV(25), .CS_SETUP(50), .EOC_TIMEOUT(2000)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Cont_En(Cont_En), .Ch_Mask(Ch_Mask),
    .AD_EOC(AD_EOC), .AD_DigData_In(AD_DigData_In), .AD_CSn(AD_CSn), .AD_Clk(AD_Clk),
    .AD_Address(AD_Address), .Result_Data(Result_Data), .Result_Ch(Result_Ch),
    .Result_Valid(Result_Valid), .Busy(Busy), .Timeout_Err(Timeout_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [3:0] ch; logic [9:0] data; } res_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobes = 0;
  int frames = 0;
  int setup_last = 0, period_last = 0, rises_last = 0, csn_rise_cyc = 0;
  logic eoc_stuck = 1'b0;
  logic [9:0] adc_val [0:10];
  logic [3:0] addr_log [$];
  res_t exp_q [$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ADC: latches the 4-bit address on the first rising edges, shifts out the
  // previous conversion MSB-first, and runs EOC low/high after CS returns high.
  initial begin : adc_model
    logic csn_p, clk_p;
    int rises, phase, dly, t_fall, t_r0;
    logic [3:0] a;
    logic [9:0] word;
    csn_p = 1'b1; clk_p = 1'b0; rises = 0; phase = 0; dly = 0;
    t_fall = 0; t_r0 = 0; a = '0; word = '0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        rises = 0; phase = 0; AD_EOC = 1'b1; csn_p = 1'b1; clk_p = 1'b0;
        continue;
      end
      if (csn_p && !AD_CSn) begin
        frames++; rises = 0; a = '0; t_fall = cyc;
        phase = 0; AD_EOC = 1'b1;
        AD_DigData_In = word[9];
      end else if (!AD_CSn && !clk_p && AD_Clk) begin
        if (rises == 0) begin setup_last = cyc - t_fall; t_r0 = cyc; end
        if (rises == 1) period_last = cyc - t_r0;
        if (rises < 4) a = {a[2:0], AD_Address};
        rises++;
      end else if (!AD_CSn && clk_p && !AD_Clk && rises < 10) begin
        AD_DigData_In = word[9 - rises];
      end else if (!csn_p && AD_CSn) begin
        addr_log.push_back(a);
        rises_last = rises;
        csn_rise_cyc = cyc;
        word = (a < 11) ? adc_val[a] : 10'd0;
        phase = 1; dly = $urandom_range(2, 10);
      end else if (phase == 1 && !eoc_stuck) begin
        dly--;
        if (dly <= 0) begin AD_EOC = 1'b0; phase = 2; dly = $urandom_range(10, 60); end
      end else if (phase == 2) begin
        dly--;
        if (dly <= 0) begin AD_EOC = 1'b1; phase = 0; end
      end
      csn_p = AD_CSn; clk_p = AD_Clk;
    end
  end

  initial begin : monitor
    res_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge CLK);
      if (Result_Valid === 1'b1) begin
        strobes++;
        check("strobe_width_prev_valid", prev_v, 0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: got ch=%0d data=%0h, expected no strobe", Result_Ch, Result_Data);
        end else begin
          e = exp_q.pop_front();
          check("result_ch", Result_Ch, e.ch);
          check("result_data", Result_Data, e.data);
        end
      end
      prev_v = Result_Valid;
    end
  end

  initial begin : watchdog
    #990_000;
    $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: one result per enabled channel, ascending.
  task automatic push_scan(input logic [10:0] m);
    for (int ch = 0; ch < 11; ch++)
      if (m[ch]) exp_q.push_back({4'(ch), adc_val[ch]});
  endtask

  task automatic pulse_start(input logic [10:0] m);
    @(negedge CLK); Ch_Mask = m; Start = 1'b1;
    @(negedge CLK); Start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (Busy && n < budget) begin @(negedge CLK); n++; end
    #1;
    check({name, "_busy_low"}, Busy, 0);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n;
    n = 0;
    while (strobes < target && n < budget) begin @(negedge CLK); n++; end
    check("strobe_reached", strobes >= target, 1);
  endtask

  // Addresses expected on the wire: enabled channels ascending, then the last one again.
  task automatic check_frames(input string name, input logic [10:0] m, input int f0, input int l0);
    logic [3:0] ea [$];
    for (int ch = 0; ch < 11; ch++) if (m[ch]) ea.push_back(4'(ch));
    ea.push_back(ea[ea.size() - 1]);
    check({name, "_frames"}, frames - f0, ea.size());
    if (addr_log.size() - l0 == ea.size())
      for (int k = 0; k < ea.size(); k++) check({name, "_addr"}, addr_log[l0 + k], ea[k]);
  endtask

  task automatic run_scan(input string name, input logic [10:0] m);
    int f0, l0;
    f0 = frames; l0 = addr_log.size();
    push_scan(m);
    pulse_start(m);
    wait_idle(name, 20000);
    repeat (3) @(negedge CLK);
    check_frames(name, m, f0, l0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int f0, l0, s0, bad, n;
    logic [10:0] m;
    for (int ch = 0; ch < 11; ch++) adc_val[ch] = 10'($urandom);

    // Reset state
    repeat (4) @(negedge CLK);
    check("rst_csn", AD_CSn, 1);
    check("rst_clk", AD_Clk, 0);
    check("rst_addr", AD_Address, 0);
    check("rst_data", Result_Data, 0);
    check("rst_ch", Result_Ch, 0);
    check("rst_valid", Result_Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_terr", Timeout_Err, 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Empty mask is ignored
    f0 = frames; bad = 0;
    pulse_start(11'h000);
    repeat (1000) begin @(negedge CLK); if (Busy !== 1'b0 || AD_CSn !== 1'b1) bad++; end
    check("mask0_quiet_cycles", bad, 0);
    check("mask0_frames", frames - f0, 0);

    // Directed two-channel scan with frame timing
    adc_val[0] = 10'h3A5; adc_val[2] = 10'h15A;
    f0 = frames; l0 = addr_log.size(); s0 = strobes;
    push_scan(11'h005);
    pulse_start(11'h005);
    wait_idle("dir", 20000);
    check("dir_strobes_at_busy_fall", strobes - s0, 2);
    repeat (3) @(negedge CLK);
    check_frames("dir", 11'h005, f0, l0);
    check("dir_queue_drained", exp_q.size(), 0);
    check("cs_setup_cycles", setup_last, 50);
    check("adclk_period", period_last, 50);
    check("rises_per_frame", rises_last, 10);
    repeat (20) @(negedge CLK);
    check("hold_ch", Result_Ch, 2);
    check("hold_data", Result_Data, 10'h15A);

    // Random masks and conversion values
    for (int it = 0; it < 4; it++) begin
      for (int ch = 0; ch < 11; ch++) adc_val[ch] = 10'($urandom);
      m = (it == 0) ? 11'h400 : 11'($urandom_range(1, 2047));
      run_scan("rnd", m);
    end

    // EOC never falls after frame 1
    eoc_stuck = 1'b1;
    s0 = strobes; n = 0;
    pulse_start(11'h003);
    while (Timeout_Err !== 1'b1 && n < 5000) begin @(posedge CLK); #1; n++; end
    check("timeout_cycles", cyc - csn_rise_cyc, 2000);
    check("timeout_busy", Busy, 0);
    check("timeout_csn", AD_CSn, 1);
    repeat (50) @(negedge CLK);
    check("timeout_no_strobe", strobes - s0, 0);
    check("timeout_sticky", Timeout_Err, 1);
    eoc_stuck = 1'b0;
    f0 = frames; l0 = addr_log.size();
    push_scan(11'h0A0);
    pulse_start(11'h0A0);
    @(negedge CLK);
    check("timeout_cleared", Timeout_Err, 0);
    wait_idle("post_to", 20000);
    repeat (3) @(negedge CLK);
    check_frames("post_to", 11'h0A0, f0, l0);
    check("post_to_queue_drained", exp_q.size(), 0);

    // Reset during SHIFT
    s0 = strobes; n = 0;
    push_scan(11'h7FF);
    pulse_start(11'h7FF);
    while (!(AD_Clk === 1'b1 && AD_CSn === 1'b0) && n < 2000) begin @(negedge CLK); n++; end
    check("midshift_reached", AD_Clk, 1);
    @(negedge CLK); RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    check("mid_rst_csn", AD_CSn, 1);
    check("mid_rst_clk", AD_Clk, 0);
    check("mid_rst_addr", AD_Address, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_valid", Result_Valid, 0);
    check("mid_rst_data", Result_Data, 0);
    check("mid_rst_ch", Result_Ch, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    f0 = frames; bad = 0;
    repeat (300) begin @(negedge CLK); if (Busy !== 1'b0 || AD_CSn !== 1'b1) bad++; end
    check("post_rst_idle", bad, 0);
    check("post_rst_no_strobe", strobes - s0, 0);
    check("post_rst_frames", frames - f0, 0);
    run_scan("after_rst", 11'h011);

    // Continuous mode on ch10
    adc_val[10] = 10'($urandom);
    f0 = frames; s0 = strobes;
    for (int k = 0; k < 3; k++) exp_q.push_back({4'd10, adc_val[10]});
    Cont_En = 1'b1;
    pulse_start(11'h400);
    wait_strobes(s0 + 1, 20000);
    pulse_start(11'h400);
    wait_strobes(s0 + 2, 20000);
    Cont_En = 1'b0;
    Ch_Mask = 11'h001;
    wait_idle("cont", 20000);
    repeat (50) @(negedge CLK);
    check("cont_strobes", strobes - s0, 3);
    check("cont_frames", frames - f0, 6);
    check("cont_queue_drained", exp_q.size(), 0);
    check("cont_last_ch", Result_Ch, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
